// File: rtl/uartcon_dbg_bridge_if.sv
// Bundle of the Rx/Tx FIFO and debug-bus signals seen by uartcon_dbg_bridge.
// The master modport is the bridge side; the slave modport is the FIFO/bus side.
interface uartcon_dbg_bridge_if #(
    parameter int ADDR_BYTES = 4,
    parameter int DATA_BYTES = 4
);
    logic                    rx_read;
    logic [7:0]              rx_rdata;
    logic                    rx_empty;
    logic                    tx_write;
    logic [7:0]              tx_wdata;
    logic                    tx_full;
    logic                    bus_req;
    logic                    bus_we;
    logic [8*ADDR_BYTES-1:0] bus_addr;
    logic [8*DATA_BYTES-1:0] bus_wdata;
    logic                    bus_ack;
    logic [8*DATA_BYTES-1:0] bus_rdata;
    logic                    bus_err;

    modport master (
        output rx_read, tx_write, tx_wdata, bus_req, bus_we, bus_addr, bus_wdata,
        input  rx_rdata, rx_empty, tx_full, bus_ack, bus_rdata, bus_err
    );

    modport slave (
        input  rx_read, tx_write, tx_wdata, bus_req, bus_we, bus_addr, bus_wdata,
        output rx_rdata, rx_empty, tx_full, bus_ack, bus_rdata, bus_err
    );
endinterface

// File: rtl/uartcon_dbg_bridge.sv
// UART debug bridge: decodes 'W'/'R' frames from the Rx FIFO into one bus access and
// pushes ACK/NAK (+ read data) into the Tx FIFO. Optional inter-byte timeout: UARTCON_DBG_TIMEOUT_EN.
module uartcon_dbg_bridge #(
    parameter int          ADDR_BYTES     = 4,
    parameter int          DATA_BYTES     = 4,
    parameter logic [7:0]  ACK_CODE       = 8'h06,
    parameter logic [7:0]  NAK_CODE       = 8'h15,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uartcon_dbg_bridge_if.master  dbg,
    output logic                  busy
);
    localparam int         AW    = 8*ADDR_BYTES;
    localparam int         DW    = 8*DATA_BYTES;
    localparam logic [7:0] OP_W  = 8'h57;
    localparam logic [7:0] OP_R  = 8'h52;
    localparam logic [2:0] ALAST = 3'(ADDR_BYTES-1);
    localparam logic [2:0] DLAST = 3'(DATA_BYTES-1);
    localparam logic [2:0] RLAST = 3'(DATA_BYTES);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

    state_t          r_state, w_next;
    logic            r_live;
    logic            r_pend;
    logic [2:0]      r_cnt;
    logic            r_we;
    logic            r_nak;
    logic            r_long;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            w_fetch;
    logic            w_pop;
    logic            w_txw;
    logic [7:0]      w_txd;
    logic            w_tmo;
    logic            w_opok;

    assign w_fetch = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_opok  = (dbg.rx_rdata == OP_W) || (dbg.rx_rdata == OP_R);
    // r_live keeps rx_read low while reset is applied and in the first cycle after it
    assign w_pop   = r_live && w_fetch && !dbg.rx_empty && !r_pend && !w_tmo;

`ifdef UARTCON_DBG_TIMEOUT_EN
    logic [31:0] r_tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if ((r_state == S_ADDR || r_state == S_DATA) && !r_pend) begin
            r_tmo <= r_tmo + 32'd1;
        end else begin
            r_tmo <= '0;
        end
    end

    assign w_tmo = (r_state == S_ADDR || r_state == S_DATA) && !r_pend
                   && (r_tmo >= TIMEOUT_CYCLES - 1);
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_txw  = 1'b0;
        w_txd  = '0;
        case (r_state)
            S_IDLE: begin
                if (r_pend) w_next = w_opok ? S_ADDR : S_RESP;
            end
            S_ADDR: begin
                if (r_pend) begin
                    if (r_cnt == ALAST) w_next = r_we ? S_DATA : S_BUS;
                end else if (w_tmo) begin
                    w_next = S_RESP;
                end
            end
            S_DATA: begin
                if (r_pend) begin
                    if (r_cnt == DLAST) w_next = S_BUS;
                end else if (w_tmo) begin
                    w_next = S_RESP;
                end
            end
            S_BUS: begin
                if (dbg.bus_ack) w_next = S_RESP;
            end
            S_RESP: begin
                w_txd = (r_cnt == 3'd0) ? (r_nak ? NAK_CODE : ACK_CODE) : r_rdata[DW-1 -: 8];
                if (!dbg.tx_full) begin
                    w_txw = 1'b1;
                    if ((r_cnt == 3'd0 && !r_long) || r_cnt == RLAST) w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live  <= 1'b0;
            r_pend  <= 1'b0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_nak   <= 1'b0;
            r_long  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_live <= 1'b1;
            r_pend <= w_pop;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (r_pend) begin
                        r_we   <= (dbg.rx_rdata == OP_W);
                        r_nak  <= !w_opok;
                        r_long <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (r_pend) begin
                        r_addr <= (r_addr << 8) | AW'(dbg.rx_rdata);
                        r_cnt  <= (r_cnt == ALAST) ? 3'd0 : r_cnt + 3'd1;
                    end else if (w_tmo) begin
                        r_nak  <= 1'b1;
                        r_long <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                S_DATA: begin
                    if (r_pend) begin
                        r_wdata <= (r_wdata << 8) | DW'(dbg.rx_rdata);
                        r_cnt   <= (r_cnt == DLAST) ? 3'd0 : r_cnt + 3'd1;
                    end else if (w_tmo) begin
                        r_nak  <= 1'b1;
                        r_long <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                S_BUS: begin
                    if (dbg.bus_ack) begin
                        r_rdata <= dbg.bus_rdata;
                        r_nak   <= dbg.bus_err;
                        r_long  <= !r_we && !dbg.bus_err;
                        r_cnt   <= '0;
                    end
                end
                S_RESP: begin
                    // read data leaves MSB first: shift after each data byte is pushed
                    if (w_txw) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt != 3'd0) r_rdata <= r_rdata << 8;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign dbg.rx_read   = w_pop;
    assign dbg.tx_write  = w_txw;
    assign dbg.tx_wdata  = w_txd;
    assign dbg.bus_req   = (r_state == S_BUS);
    assign dbg.bus_we    = (r_state == S_BUS) && r_we;
    assign dbg.bus_addr  = r_addr;
    assign dbg.bus_wdata = r_wdata;
    assign busy          = (r_state != S_IDLE);
endmodule
